// File: rtl/mem_pkg.sv
// Shared memory-command encoding and arbiter state type for the RAM port logic.
package mem_pkg;

    localparam logic [1:0] MREAD  = 2'd1;
    localparam logic [1:0] MNONE  = 2'd2;
    localparam logic [1:0] MWRITE = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA
    } arb_state_t;

    function automatic logic is_mem_op(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way winner select: a lone request wins outright; a tie goes to the port
// that did not win last (round-robin) or always to port 0 (fixed priority).
module arb_pick #(
    parameter int RR = 1
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic win_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        win_o   = 1'b0;
        if (req0_i && req1_i) begin
            win_o = (RR != 0) ? ~last_i : 1'b0;
        end else if (req1_i) begin
            win_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between the CPU (port 0) and the
// auxiliary master (port 1); every access runs arbitrate -> issue -> capture.
//
//   state | meaning
//   IDLE  | sample requests, latch winner's command onto the RAM bus
//   ISSUE | command on the RAM bus, grant pulse to the winner
//   RDATA | RAM read data arriving, captured into rdata at the end
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16,
    parameter int RR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [1:0]    cmd0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic [1:0]    cmd_lat_q, cmd_lat_d;
    logic [1:0]    mem_cmd_q, mem_cmd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

    logic          pick_valid;
    logic          pick_win;
    logic [1:0]    cmd_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    arb_pick #(
        .RR (RR)
    ) u_pick (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    assign cmd_sel   = pick_win ? cmd1   : cmd0;
    assign addr_sel  = pick_win ? addr1  : addr0;
    assign wdata_sel = pick_win ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            cmd_lat_q   <= MNONE;
            mem_cmd_q   <= MNONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            cmd_lat_q   <= cmd_lat_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        cmd_lat_d   = cmd_lat_q;
        mem_cmd_d   = MNONE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d       = pick_win;
                    last_d      = pick_win;
                    cmd_lat_d   = cmd_sel;
                    // No-op commands are granted but never reach the RAM.
                    mem_cmd_d   = is_mem_op(cmd_sel) ? cmd_sel : MNONE;
                    mem_addr_d  = addr_sel;
                    mem_wdata_d = wdata_sel;
                    gnt0_d      = ~pick_win;
                    gnt1_d      = pick_win;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (cmd_lat_q == MREAD) ? RDATA : IDLE;
            end
            RDATA: begin
                rdata_d   = mem_rdata;
                rvalid0_d = ~win_q;
                rvalid1_d = win_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign mem_cmd   = mem_cmd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a RAM model behind the round-robin
// instance, a scoreboard of expected grants/reads, and a fixed-priority instance.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;

    logic        gnt0_f, gnt1_f, rvalid0_f, rvalid1_f;
    logic [15:0] rdata_f, mem_wdata_f;
    logic [15:0] mem_rdata_f = 16'h5A5A;
    logic [1:0]  mem_cmd_f;
    logic [8:0]  mem_addr_f;

    logic [15:0] ram [0:511];

    typedef struct {
        logic        port;
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
    } gnt_exp_t;

    typedef struct {
        logic        port;
        logic [15:0] data;
    } rd_exp_t;

    gnt_exp_t gq[$];
    rd_exp_t  rq[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(9), .DW(16), .RR(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(9), .DW(16), .RR(0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .cmd0(cmd0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_f), .rvalid0(rvalid0_f),
        .req1(req1), .cmd1(cmd1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_f), .rvalid1(rvalid1_f),
        .rdata(rdata_f), .mem_cmd(mem_cmd_f), .mem_addr(mem_addr_f),
        .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f)
    );

    // Synchronous-read RAM: data for an MREAD appears the following cycle.
    always @(posedge clk) begin
        if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
        if (mem_cmd == MREAD)  mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        gnt_exp_t g;
        rd_exp_t  r;
        chk("gnt_onehot",    {31'd0, gnt0 & gnt1},       32'd0);
        chk("rvalid_onehot", {31'd0, rvalid0 & rvalid1}, 32'd0);
        if (!mon_en) return;
        if (gnt0 | gnt1) begin
            if (gq.size() == 0) begin
                chk("gnt_unexpected", {30'd0, gnt1, gnt0}, 32'd0);
            end else begin
                g = gq.pop_front();
                chk("gnt_port",  {31'd0, gnt1},      {31'd0, g.port});
                chk("gnt_cmd",   {30'd0, mem_cmd},   {30'd0, g.cmd});
                chk("gnt_addr",  {23'd0, mem_addr},  {23'd0, g.addr});
                chk("gnt_wdata", {16'd0, mem_wdata}, {16'd0, g.wdata});
            end
        end else begin
            chk("mem_cmd_idle", {30'd0, mem_cmd}, {30'd0, MNONE});
        end
        if (rvalid0 | rvalid1) begin
            if (rq.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("rvalid_port", {31'd0, rvalid1}, {31'd0, r.port});
                chk("rdata",       {16'd0, rdata},   {16'd0, r.data});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic set_req(input logic p, input logic [1:0] c, input logic [8:0] a,
                           input logic [15:0] d);
        if (p) begin
            req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic push_gnt(input logic p, input logic [1:0] c, input logic [8:0] a,
                            input logic [15:0] d);
        gnt_exp_t g;
        g.port = p; g.cmd = c; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic push_rd(input logic p, input logic [15:0] d);
        rd_exp_t r;
        r.port = p; r.data = d;
        rq.push_back(r);
    endtask

    task automatic do_write(input logic p, input logic [8:0] a, input logic [15:0] d);
        set_req(p, MWRITE, a, d);
        push_gnt(p, MWRITE, a, d);
        tick();
        chk("wr_gnt_lat", {31'd0, p ? gnt1 : gnt0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int ng;
        int nf0, nr0;
        reset = 1'b1;
        req0 = 1'b0; cmd0 = MNONE; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; cmd1 = MNONE; addr1 = '0; wdata1 = '0;

        tick();
        chk("rst_gnt",     {30'd0, gnt1, gnt0},       32'd0);
        chk("rst_rvalid",  {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_mem_cmd", {30'd0, mem_cmd},          {30'd0, MNONE});
        chk("rst_bus",     {7'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst_rdata",   {16'd0, rdata},            32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single write from port 0; the one-cycle command window is the gnt cycle.
        set_req(1'b0, MWRITE, 9'h05, 16'hABCD);
        push_gnt(1'b0, MWRITE, 9'h05, 16'hABCD);
        tick();
        chk("wr_gnt0",    {31'd0, gnt0},    32'd1);
        chk("wr_mem_cmd", {30'd0, mem_cmd}, {30'd0, MWRITE});
        req0 = 1'b0;
        tick();
        chk("wr_cmd_one_cycle", {30'd0, mem_cmd}, {30'd0, MNONE});
        repeat (3) tick();

        do_write(1'b0, 9'h05, 16'h1234);
        do_write(1'b0, 9'h10, 16'h1111);
        do_write(1'b1, 9'h20, 16'h2222);

        // Port 1 read: gnt at +1, rvalid at +3.
        set_req(1'b1, MREAD, 9'h05, 16'h0000);
        push_gnt(1'b1, MREAD, 9'h05, 16'h0000);
        push_rd(1'b1, 16'h1234);
        tick();
        chk("rd_gnt_lat", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        tick();
        chk("rd_no_early_rvalid", {31'd0, rvalid1}, 32'd0);
        tick();
        chk("rd_rvalid_lat", {31'd0, rvalid1}, 32'd1);
        chk("rd_port0_quiet", {30'd0, gnt0, rvalid0}, 32'd0);
        repeat (2) tick();
        chk("rd_queues_empty", gq.size() + rq.size(), 32'd0);

        // Continuous contention from reset, round-robin.
        reset = 1'b1;
        set_req(1'b0, MREAD, 9'h10, 16'h0000);
        set_req(1'b1, MREAD, 9'h20, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            push_gnt(1'b0, MREAD, 9'h10, 16'h0000);
            push_gnt(1'b1, MREAD, 9'h20, 16'h0000);
            push_rd(1'b0, 16'h1111);
            push_rd(1'b1, 16'h2222);
        end
        tick();
        reset = 1'b0;
        ng = 0;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            tick();
            if (gnt0 | gnt1) ng++;
        end
        chk("rr_grant_count", ng, 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 10 && (gq.size() + rq.size()) != 0; i++) tick();
        repeat (3) tick();
        chk("rr_gq_empty", gq.size(), 32'd0);
        chk("rr_rq_empty", rq.size(), 32'd0);

        // Same contention on the fixed-priority instance.
        mon_en = 1'b0;
        reset = 1'b1;
        set_req(1'b0, MREAD, 9'h10, 16'h0000);
        set_req(1'b1, MREAD, 9'h20, 16'h0000);
        tick();
        reset = 1'b0;
        nf0 = 0; nr0 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("fp_no_port1", {30'd0, gnt1_f, rvalid1_f}, 32'd0);
            if (gnt0_f) begin
                nf0++;
                chk("fp_addr", {23'd0, mem_addr_f}, 32'h10);
            end
            if (rvalid0_f) begin
                nr0++;
                chk("fp_rdata", {16'd0, rdata_f}, 32'h5A5A);
            end
        end
        chk("fp_gnt0_count",   nf0, 32'd4);
        chk("fp_rvalid0_count", nr0, 32'd4);
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // No-op command: granted, never reaches the RAM, never returns data.
        set_req(1'b0, 2'b00, 9'h07, 16'h0BAD);
        push_gnt(1'b0, MNONE, 9'h07, 16'h0BAD);
        tick();
        chk("noop_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        repeat (5) tick();

        // Reset during the ISSUE cycle of a port 1 read aborts it.
        set_req(1'b1, MREAD, 9'h20, 16'h0000);
        push_gnt(1'b1, MREAD, 9'h20, 16'h0000);
        tick();
        chk("abort_gnt1", {31'd0, gnt1}, 32'd1);
        reset = 1'b1;
        req1 = 1'b0;
        tick();
        chk("abort_mem_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        reset = 1'b0;
        repeat (6) tick();
        set_req(1'b0, MWRITE, 9'h30, 16'h3333);
        set_req(1'b1, MWRITE, 9'h31, 16'h4444);
        push_gnt(1'b0, MWRITE, 9'h30, 16'h3333);
        tick();
        chk("post_rst_tie", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();

        // A req0 pulse confined to port 1's ISSUE cycle is never served.
        set_req(1'b1, MREAD, 9'h10, 16'h0000);
        push_gnt(1'b1, MREAD, 9'h10, 16'h0000);
        push_rd(1'b1, 16'h1111);
        tick();
        chk("pulse_gnt1", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        set_req(1'b0, MWRITE, 9'h40, 16'h5555);
        tick();
        req0 = 1'b0;
        repeat (6) tick();
        chk("pulse_gq_empty", gq.size(), 32'd0);
        chk("pulse_rq_empty", rq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
